dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 22 ++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, read owners and access sizes.
package dmem_arbiter_pkg;

    typedef enum logic {
        S_FREE = 1'b0,
        S_BDTU = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_BDTU = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_HOST = 2'd3
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [3:0] STARVE_SAT = 4'd15;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: BDTU lock, CPU-over-host priority with host anti-starvation,
// and a registered read owner so read data returns while the next access issues.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int HOST_STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        b_busy,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic        b_rd,
    input  logic        b_wr,
    input  logic [1:0]  b_size,
    output logic [31:0] b_rdata,
    input  logic        c_req,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic        c_wr,
    input  logic [1:0]  c_size,
    output logic        c_stall,
    output logic [31:0] c_rdata,
    input  logic        h_req,
    input  logic [31:0] h_addr,
    input  logic [31:0] h_wdata,
    input  logic        h_wr,
    output logic        h_gnt,
    output logic        h_rvalid,
    output logic [31:0] h_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_size,
    input  logic [31:0] m_rdata
);

    localparam logic [3:0] LP_STARVE_MAX = 4'(HOST_STARVE_MAX);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_starve;
    logic [3:0] w_starve_nxt;
    owner_t     r_rd_owner;
    owner_t     w_rd_owner_nxt;
    owner_t     w_owner;
    logic       w_host_wins;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FREE;
            r_starve   <= 4'd0;
            r_rd_owner <= OWN_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_starve   <= w_starve_nxt;
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    // The lock follows b_busy combinationally in both directions, so a rising
    // b_busy owns memory immediately and a falling one re-arbitrates without a bubble.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FREE:  if (b_busy)  w_state_nxt = S_BDTU;
            S_BDTU:  if (!b_busy) w_state_nxt = S_FREE;
            default: w_state_nxt = S_FREE;
        endcase
    end

    assign w_host_wins = h_req && (!c_req || (r_starve >= LP_STARVE_MAX));

    always_comb begin
        w_owner = OWN_NONE;
        if (!rst_n)           w_owner = OWN_NONE;
        else if (b_busy)      w_owner = OWN_BDTU;
        else if (w_host_wins) w_owner = OWN_HOST;
        else if (c_req)       w_owner = OWN_CPU;
    end

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        m_size  = SIZE_BYTE;
        c_stall = c_req;
        h_gnt   = 1'b0;
        case (w_owner)
            OWN_BDTU: begin
                m_en    = b_rd | b_wr;
                m_we    = b_wr;
                m_addr  = b_addr;
                m_wdata = b_wdata;
                m_size  = b_size;
            end
            OWN_CPU: begin
                m_en    = 1'b1;
                m_we    = c_wr;
                m_addr  = c_addr;
                m_wdata = c_wdata;
                m_size  = c_size;
                c_stall = 1'b0;
            end
            OWN_HOST: begin
                m_en    = 1'b1;
                m_we    = h_wr;
                m_addr  = h_addr;
                m_wdata = h_wdata;
                m_size  = SIZE_WORD;
                h_gnt   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_starve_nxt = 4'd0;
        if (h_req && !h_gnt)
            w_starve_nxt = (r_starve == STARVE_SAT) ? STARVE_SAT : r_starve + 4'd1;
    end

    assign w_rd_owner_nxt = (m_en && !m_we) ? w_owner : OWN_NONE;

    assign b_rdata  = m_rdata;
    assign c_rdata  = m_rdata;
    assign h_rdata  = m_rdata;
    assign h_rvalid = (r_rd_owner == OWN_HOST);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural arbitration model with a shadow memory,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_arbiter;

    localparam int MAXS = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        b_busy, b_rd, b_wr;
    logic [31:0] b_addr, b_wdata;
    logic [1:0]  b_size;
    logic [31:0] b_rdata;
    logic        c_req, c_wr;
    logic [31:0] c_addr, c_wdata;
    logic [1:0]  c_size;
    logic        c_stall;
    logic [31:0] c_rdata;
    logic        h_req, h_wr;
    logic [31:0] h_addr, h_wdata;
    logic        h_gnt, h_rvalid;
    logic [31:0] h_rdata;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_size;
    logic [31:0] m_rdata = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem  [1024];
    logic [31:0] gold [1024];

    dmem_arbiter #(.HOST_STARVE_MAX(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .b_busy(b_busy), .b_addr(b_addr), .b_wdata(b_wdata), .b_rd(b_rd), .b_wr(b_wr),
        .b_size(b_size), .b_rdata(b_rdata),
        .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_wr(c_wr), .c_size(c_size),
        .c_stall(c_stall), .c_rdata(c_rdata),
        .h_req(h_req), .h_addr(h_addr), .h_wdata(h_wdata), .h_wr(h_wr), .h_gnt(h_gnt),
        .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory driven by whatever the DUT issues.
    always @(posedge clk) begin
        if (m_en && m_we)  mem[m_addr[11:2]] <= m_wdata;
        if (m_en && !m_we) m_rdata <= mem[m_addr[11:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Behavioural reference: who owns memory this cycle, straight from the priority rules.
    initial begin : model
        int          starve;
        int          rd_pending;
        logic [31:0] rd_data;
        int          own;
        logic        e_en, e_we, e_gnt, e_stall;
        logic [31:0] e_addr, e_wdata;
        logic [1:0]  e_size;
        starve = 0;
        rd_pending = 0;
        rd_data = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = 32'hA5000000 ^ 32'(i * 32'h01010101);
            gold[i] = 32'hA5000000 ^ 32'(i * 32'h01010101);
        end
        mem[32'h100 >> 2]  = 32'hDEADBEEF;
        gold[32'h100 >> 2] = 32'hDEADBEEF;
        mem[32'h40 >> 2]   = 32'h4040A5A5;
        gold[32'h40 >> 2]  = 32'h4040A5A5;
        forever begin
            @(negedge clk);
            // own: 0 none, 1 BDTU, 2 CPU, 3 host
            if (!rst_n)                                   own = 0;
            else if (b_busy)                              own = 1;
            else if (h_req && (!c_req || starve >= MAXS)) own = 3;
            else if (c_req)                               own = 2;
            else                                          own = 0;
            e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_size = 2'b00;
            e_gnt = (own == 3);
            e_stall = c_req && (own != 2);
            if (own == 1) begin
                e_en = b_rd | b_wr; e_we = b_wr; e_addr = b_addr; e_wdata = b_wdata; e_size = b_size;
            end else if (own == 2) begin
                e_en = 1; e_we = c_wr; e_addr = c_addr; e_wdata = c_wdata; e_size = c_size;
            end else if (own == 3) begin
                e_en = 1; e_we = h_wr; e_addr = h_addr; e_wdata = h_wdata; e_size = 2'b10;
            end
            chk("m_en", 32'(m_en), 32'(e_en));
            chk("m_we", 32'(m_we), 32'(e_we));
            chk("m_addr", m_addr, e_addr);
            chk("m_wdata", m_wdata, e_wdata);
            chk("m_size", 32'(m_size), 32'(e_size));
            chk("c_stall", 32'(c_stall), 32'(e_stall));
            chk("h_gnt", 32'(h_gnt), 32'(e_gnt));
            chk("h_rvalid", 32'(h_rvalid), 32'(rst_n && rd_pending == 3));
            if (rst_n && rd_pending != 0) begin
                chk("b_rdata", b_rdata, rd_data);
                chk("c_rdata", c_rdata, rd_data);
                chk("h_rdata", h_rdata, rd_data);
            end
            @(posedge clk);
            if (!rst_n) begin
                starve = 0;
                rd_pending = 0;
            end else begin
                if (h_req && !e_gnt) starve = (starve < 15) ? starve + 1 : 15;
                else                 starve = 0;
                if (e_en && !e_we) begin
                    rd_pending = own;
                    rd_data = gold[e_addr[11:2]];
                end else begin
                    rd_pending = 0;
                end
                if (e_en && e_we) gold[e_addr[11:2]] = e_wdata;
            end
        end
    end

    task automatic idle();
        b_busy = 0; b_rd = 0; b_wr = 0; b_addr = 0; b_wdata = 0; b_size = 2'b10;
        c_req = 0; c_wr = 0; c_addr = 0; c_wdata = 0; c_size = 2'b10;
        h_req = 0; h_wr = 0; h_addr = 0; h_wdata = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int   gnt_cycle;
        logic g;
        logic h_pend;
        idle();
        rst_n = 0;
        c_req = 1;
        #1;
        @(negedge clk);
        chk("reset_m_en", 32'(m_en), 32'd0);
        chk("reset_h_gnt", 32'(h_gnt), 32'd0);
        chk("reset_c_stall", 32'(c_stall), 32'd1);
        tick();
        rst_n = 1;
        idle();
        tick();

        // CPU read of a preloaded word
        c_req = 1; c_addr = 32'h100; c_wr = 0;
        @(negedge clk);
        chk("cpu_rd_stall", 32'(c_stall), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("cpu_rd_data", c_rdata, 32'hDEADBEEF);
        tick();

        // Six-cycle BDTU lock with the CPU requesting throughout
        for (int i = 0; i < 6; i++) begin
            b_busy = 1; b_rd = (i < 4); b_addr = 32'h200 + 32'((i < 4 ? i : 3) * 4);
            c_req = 1; c_addr = 32'h600; c_wr = 0;
            @(negedge clk);
            chk("ldm_c_stall", 32'(c_stall), 32'd1);
            chk("ldm_m_addr", m_addr, 32'h200 + 32'((i < 4 ? i : 3) * 4));
            tick();
        end
        b_busy = 0; b_rd = 0;
        @(negedge clk);
        chk("post_ldm_cpu_grant", 32'(c_stall), 32'd0);
        chk("post_ldm_m_addr", m_addr, 32'h600);
        tick();
        idle();
        tick();

        // Host starvation against a continuous CPU stream
        gnt_cycle = 0;
        for (int i = 1; i <= 12; i++) begin
            c_req = 1; c_addr = 32'h700; c_wr = 0;
            h_req = (gnt_cycle == 0); h_addr = 32'h80; h_wr = 0;
            @(negedge clk);
            if (h_req) begin
                chk("starve_c_stall", 32'(c_stall), 32'(i == 9));
                if (h_gnt) gnt_cycle = i;
            end
            tick();
        end
        chk("starve_gnt_cycle", 32'(gnt_cycle), 32'd9);
        idle();
        tick();

        // Host read granted just before the BDTU lock
        h_req = 1; h_addr = 32'h40; h_wr = 0;
        @(negedge clk);
        chk("pre_lock_h_gnt", 32'(h_gnt), 32'd1);
        tick();
        idle();
        b_busy = 1; b_rd = 1; b_addr = 32'h300;
        @(negedge clk);
        chk("lock_h_rvalid", 32'(h_rvalid), 32'd1);
        chk("lock_h_rdata", h_rdata, 32'h4040A5A5);
        chk("lock_m_addr", m_addr, 32'h300);
        tick();
        idle();
        tick();

        // Reset in the third cycle of a BDTU store sequence
        for (int i = 0; i < 3; i++) begin
            b_busy = 1; b_wr = 1; b_addr = 32'h400 + 32'(i * 4); b_wdata = 32'h1000 + 32'(i);
            if (i == 2) rst_n = 0;
            @(negedge clk);
            if (i == 2) begin
                chk("stm_reset_m_we", 32'(m_we), 32'd0);
                chk("stm_reset_m_en", 32'(m_en), 32'd0);
            end
            tick();
        end
        tick();
        rst_n = 1;
        idle();
        c_req = 1; c_wr = 1; c_addr = 32'h500; c_wdata = 32'hCAFE0001;
        @(negedge clk);
        chk("post_reset_cpu_we", 32'(m_we), 32'd1);
        chk("post_reset_cpu_stall", 32'(c_stall), 32'd0);
        tick();
        idle();
        tick();

        // Randomized traffic
        g = 0;
        h_pend = 0;
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if (b_busy) b_busy = ($urandom_range(0, 9) < 8);
            else        b_busy = ($urandom_range(0, 9) == 0);
            b_rd = 0; b_wr = 0;
            case ($urandom_range(0, 2))
                0: b_rd = 1;
                1: b_wr = 1;
                default: ;
            endcase
            b_addr = 32'($urandom_range(0, 1023)) << 2;
            b_wdata = $urandom;
            b_size = 2'($urandom_range(0, 2));
            c_req = $urandom_range(0, 1) == 1;
            c_wr = $urandom_range(0, 1) == 1;
            c_addr = 32'($urandom_range(0, 1023)) << 2;
            c_wdata = $urandom;
            c_size = 2'($urandom_range(0, 2));
            if (!(h_pend && !g)) begin
                h_req = ($urandom_range(0, 9) < 4);
                h_wr = $urandom_range(0, 1) == 1;
                h_addr = 32'($urandom_range(0, 1023)) << 2;
                h_wdata = $urandom;
            end
            h_pend = h_req;
            @(negedge clk);
            g = h_gnt;
            tick();
        end
        idle();
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
